if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage. Owns the fetch PC and the single-outstanding instruction-memory handshake, and drives the IF/ID pipeline register (instruction, pc, valid) that decode consumes.
- Obeys the decode stage's PC_Write and IF_ID_Write stall controls and its flush / branch_taken redirect.

---
 rtl/if_fetch_stage_if.sv | 11 +
 rtl/if_fetch_stage.sv | 121 ++++++++++++
 tb/tb_if_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle for the fetch stage.
// The fetch stage is the master; the instruction memory is the slave.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake, IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt outputs.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PC_Write,
  input  logic                  IF_ID_Write,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  if_fetch_stage_if.master      imem,
  output logic [31:0]           instruction,
  output logic [31:0]           pc,
  output logic                  if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_kill;
  logic [31:0] r_hold_instr;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_take;
  logic        w_rsp_live;
  logic        w_deliver;
  logic [31:0] w_dlv_instr;

  assign w_redirect = flush & branch_taken;
  assign w_target   = branch_target & 32'hFFFF_FFFC;
  assign w_take     = IF_ID_Write & PC_Write;
  assign w_rsp_live = (r_state == S_WAIT) & imem.imem_rvalid & ~r_kill & ~w_redirect;
  assign w_deliver  = (w_rsp_live | ((r_state == S_HOLD) & ~w_redirect)) & w_take;
  // fetch_pc does not move while a response is buffered, so only the data needs holding
  assign w_dlv_instr = (r_state == S_HOLD) ? r_hold_instr : imem.imem_rdata;

  assign imem.imem_req  = rst & (r_state == S_REQ) & ~w_redirect;
  assign imem.imem_addr = r_fetch_pc;

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign if_valid    = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_REQ;
      r_fetch_pc   <= RESET_PC;
      r_kill       <= 1'b0;
      r_hold_instr <= '0;
      r_instr      <= NOP_INSTR;
      r_pc         <= '0;
      r_valid      <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (!w_redirect) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            r_kill <= 1'b0;
            if (w_rsp_live && !w_take) begin
              r_hold_instr <= imem.imem_rdata;
              r_state      <= S_HOLD;
            end else begin
              r_state <= S_REQ;
            end
          end else if (w_redirect) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_redirect || w_take) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase

      if (w_redirect)     r_fetch_pc <= w_target;
      else if (w_deliver) r_fetch_pc <= r_fetch_pc + 32'd4;

      if (flush) begin
        r_instr <= NOP_INSTR;
        r_pc    <= '0;
        r_valid <= 1'b0;
      end else if (w_deliver) begin
        r_instr <= w_dlv_instr;
        r_pc    <= r_fetch_pc;
        r_valid <= 1'b1;
      end else if (IF_ID_Write) begin
        r_instr <= NOP_INSTR;
        r_pc    <= '0;
        r_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if ((r_state == S_HOLD) || (!IF_ID_Write && r_valid)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (w_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized stall/flush traffic
// checked every cycle against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_Write, IF_ID_Write, flush, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction, pc;
  logic        if_valid;
  logic [31:0] instr2, pc2;
  logic        valid2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] ps, pf, ps2, pf2;
`endif

  if_fetch_stage_if imem_if();
  if_fetch_stage_if imem2_if();

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .clk(clk), .rst(rst), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(imem_if), .instruction(instruction), .pc(pc), .if_valid(if_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cnt(ps), .perf_flush_cnt(pf)
`endif
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst), .PC_Write(1'b1), .IF_ID_Write(1'b1),
    .flush(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
    .imem(imem2_if), .instruction(instr2), .pc(pc2), .if_valid(valid2)
`ifdef IF_PERF_CNT_EN
    , .perf_stall_cnt(ps2), .perf_flush_cnt(pf2)
`endif
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // stimulus for the coming cycle
  logic        s_rst, s_pcw, s_wr, s_fl, s_bt, s_force_rv;
  logic [31:0] s_tgt;
  int unsigned lat;

  // memory responder state
  logic        r_pend;
  logic [31:0] r_addr;
  int unsigned r_cnt;
  logic        r2_pend;
  logic [31:0] r2_addr;
  logic [31:0] q2[$];

  // behavioural model of the fetch stage
  logic [31:0] m_fpc, m_bi, m_instr, m_pc;
  logic        m_busy, m_kill, m_buf, m_valid;
  logic [31:0] m_stall, m_flcnt;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fpc = 32'h0; m_busy = 1'b0; m_kill = 1'b0; m_buf = 1'b0; m_bi = '0;
    m_instr = NOP; m_pc = '0; m_valid = 1'b0; m_stall = '0; m_flcnt = '0;
  endtask

  task automatic set_idle();
    s_pcw = 1'b1; s_wr = 1'b1; s_fl = 1'b0; s_bt = 1'b0; s_tgt = '0; s_force_rv = 1'b0;
  endtask

  task automatic model_step(input logic rv);
    logic        redir, take, dl, req;
    logic [31:0] di;
    redir = s_fl & s_bt;
    take  = s_wr & s_pcw;
    req   = !m_busy && !m_buf && !redir;
    dl = 1'b0; di = '0;
    if (m_buf || (!s_wr && m_valid)) m_stall = m_stall + 32'd1;
    if (redir) m_flcnt = m_flcnt + 32'd1;
    if (m_busy) begin
      if (rv) begin
        m_busy = 1'b0;
        if (m_kill || redir) m_kill = 1'b0;
        else if (take) begin dl = 1'b1; di = mem(m_fpc); end
        else begin m_buf = 1'b1; m_bi = mem(m_fpc); end
      end else if (redir) m_kill = 1'b1;
    end else if (m_buf) begin
      if (redir) m_buf = 1'b0;
      else if (take) begin dl = 1'b1; di = m_bi; m_buf = 1'b0; end
    end else if (req) m_busy = 1'b1;
    if (s_fl) begin m_instr = NOP; m_pc = '0; m_valid = 1'b0; end
    else if (dl) begin m_instr = di; m_pc = m_fpc; m_valid = 1'b1; end
    else if (s_wr) begin m_instr = NOP; m_pc = '0; m_valid = 1'b0; end
    if (redir) m_fpc = s_tgt & 32'hFFFF_FFFC;
    else if (dl) m_fpc = m_fpc + 32'd4;
  endtask

  task automatic cycle();
    logic rv, fire, e_req;
    @(negedge clk);
    rst = s_rst; PC_Write = s_pcw; IF_ID_Write = s_wr;
    flush = s_fl; branch_taken = s_bt; branch_target = s_tgt;
    fire = r_pend && (r_cnt == 0);
    rv   = fire || s_force_rv;
    imem_if.imem_rvalid  = rv;
    imem_if.imem_rdata   = fire ? mem(r_addr) : 32'hDEAD_BEEF;
    imem2_if.imem_rvalid = r2_pend;
    imem2_if.imem_rdata  = mem(r2_addr);
    #2;
    e_req = s_rst && !m_busy && !m_buf && !(s_fl && s_bt);
    chk("imem_req", 32'(imem_if.imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_if.imem_addr, m_fpc);
    chk("instruction", instruction, m_instr);
    chk("pc", pc, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
`ifdef IF_PERF_CNT_EN
    chk("perf_stall", ps, m_stall);
    chk("perf_flush", pf, m_flcnt);
`endif
    r2_pend = imem2_if.imem_req;
    r2_addr = imem2_if.imem_addr;
    if (imem2_if.imem_req) q2.push_back(imem2_if.imem_addr);
    if (s_rst) model_step(rv);
    else model_reset();
    if (fire) r_pend = 1'b0;
    else if (r_pend) r_cnt = r_cnt - 1;
    if (imem_if.imem_req) begin r_pend = 1'b1; r_addr = imem_if.imem_addr; r_cnt = lat - 1; end
  endtask

  task automatic wait_req(input int unsigned max);
    for (int unsigned i = 0; i < max; i++) begin
      cycle();
      if (imem_if.imem_req) return;
    end
    n_chk++; n_err++;
    $display("FAIL wait_req: no imem_req within %0d cycles", max);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; PC_Write = 1'b1; IF_ID_Write = 1'b1; flush = 1'b0; branch_taken = 1'b0;
    branch_target = '0;
    imem_if.imem_rvalid = 1'b0; imem_if.imem_rdata = '0;
    imem2_if.imem_rvalid = 1'b0; imem2_if.imem_rdata = '0;
    r_pend = 1'b0; r_addr = '0; r_cnt = 0; r2_pend = 1'b0; r2_addr = '0; lat = 1;
    set_idle(); s_rst = 1'b0; model_reset();

    repeat (3) cycle();
    chk("reset_instr", instruction, NOP);
    chk("reset_req", 32'(imem_if.imem_req), 32'd0);

    // back-to-back fetch with 1-cycle memory
    s_rst = 1'b1;
    cycle();
    chk("first_req", 32'(imem_if.imem_req), 32'd1);
    chk("first_addr", imem_if.imem_addr, 32'h0);
    cycle();
    cycle();
    chk("ifid0_instr", instruction, 32'h0010_0093);
    chk("ifid0_pc", pc, 32'h0);
    chk("ifid0_valid", 32'(if_valid), 32'd1);
    chk("second_addr", imem_if.imem_addr, 32'h4);
    chk("wrap_ifid_pc", pc2, 32'hFFFF_FFFC);
    cycle();
    chk("gap_valid", 32'(if_valid), 32'd0);
    chk("gap_instr", instruction, NOP);
    cycle();
    chk("ifid1_instr", instruction, 32'h0020_0113);
    chk("ifid1_pc", pc, 32'h4);
    chk("third_addr", imem_if.imem_addr, 32'h8);
    chk("wrap_fetch_count", 32'(q2.size() >= 2), 32'd1);
    if (q2.size() >= 2) begin
      chk("wrap_fetch0", q2[0], 32'hFFFF_FFFC);
      chk("wrap_fetch1", q2[1], 32'h0);
    end

    // stall while the response for pc=8 arrives
    s_pcw = 1'b0; s_wr = 1'b0;
    repeat (3) cycle();
    chk("hold_req", 32'(imem_if.imem_req), 32'd0);
    set_idle();
    cycle();
    cycle();
    chk("hold_release_pc", pc, 32'h8);
    chk("hold_release_instr", instruction, mem(32'h8));
    chk("after_hold_addr", imem_if.imem_addr, 32'hC);
    cycle();

    // redirect while waiting on a slow response for pc=0x10
    lat = 3;
    cycle();
    s_fl = 1'b1; s_bt = 1'b1; s_tgt = 32'h43;
    cycle();
    set_idle();
    cycle();
    chk("kill_bubble", 32'(if_valid), 32'd0);
    lat = 1;
    wait_req(8);
    chk("redirect_addr", imem_if.imem_addr, 32'h40);
    cycle();

    // redirect in REQ with a coincident response and a stall
    s_fl = 1'b1; s_bt = 1'b1; s_tgt = 32'h80; s_wr = 1'b0; s_force_rv = 1'b1;
    cycle();
    chk("redir_req_suppressed", 32'(imem_if.imem_req), 32'd0);
    chk("pre_redir_pc", pc, 32'h40);
    set_idle();
    lat = 3;
    cycle();
    chk("redir_bubble", 32'(if_valid), 32'd0);
    chk("redir_addr", imem_if.imem_addr, 32'h80);

    // asynchronous reset mid-WAIT, then a stale response after release
    cycle();
    #1 rst = 1'b0; s_rst = 1'b0;
    #1;
    chk("async_rst_instr", instruction, NOP);
    chk("async_rst_valid", 32'(if_valid), 32'd0);
    chk("async_rst_req", 32'(imem_if.imem_req), 32'd0);
    model_reset();
    r_pend = 1'b1; r_cnt = 2;
    repeat (2) cycle();
    s_rst = 1'b1; lat = 1;
    cycle();
    chk("restart_req", 32'(imem_if.imem_req), 32'd1);
    chk("restart_addr", imem_if.imem_addr, 32'h0);

    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      s_pcw = ($urandom % 5) != 0;
      s_wr  = ($urandom % 5) != 0;
      s_fl  = ($urandom % 12) == 0;
      s_bt  = ($urandom % 3) != 0;
      case ($urandom % 4)
        0: s_tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        1: s_tgt = $urandom;
        default: s_tgt = $urandom & 32'hFF;
      endcase
      s_force_rv = 1'b0;
      lat = 1 + ($urandom % 3);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
